// File: rtl/axi_mst.sv
// Single-beat AXI4 master: one request in, one AXI read or write out, one response back.
// Optional watchdog enabled by defining AXI_MST_TIMEOUT_EN.
package types_amba_pkg;
  localparam int CFG_SYSBUS_ADDR_BITS  = 48;
  localparam int CFG_SYSBUS_DATA_BITS  = 64;
  localparam int CFG_SYSBUS_DATA_BYTES = 8;
  localparam int CFG_SYSBUS_ID_BITS    = 5;
  localparam int CFG_SYSBUS_USER_BITS  = 1;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [CFG_SYSBUS_ADDR_BITS-1:0] addr;
    logic [7:0]                      len;
    logic [2:0]                      size;
    logic [1:0]                      burst;
    logic                            lock;
    logic [3:0]                      cache;
    logic [2:0]                      prot;
    logic [3:0]                      qos;
    logic [3:0]                      region;
  } axi4_metadata_type;

  typedef struct packed {
    logic                             aw_valid;
    axi4_metadata_type                aw_bits;
    logic [CFG_SYSBUS_ID_BITS-1:0]    aw_id;
    logic [CFG_SYSBUS_USER_BITS-1:0]  aw_user;
    logic                             w_valid;
    logic [CFG_SYSBUS_DATA_BITS-1:0]  w_data;
    logic                             w_last;
    logic [CFG_SYSBUS_DATA_BYTES-1:0] w_strb;
    logic [CFG_SYSBUS_USER_BITS-1:0]  w_user;
    logic                             b_ready;
    logic                             ar_valid;
    axi4_metadata_type                ar_bits;
    logic [CFG_SYSBUS_ID_BITS-1:0]    ar_id;
    logic [CFG_SYSBUS_USER_BITS-1:0]  ar_user;
    logic                             r_ready;
  } axi4_master_out_type;

  typedef struct packed {
    logic                            aw_ready;
    logic                            w_ready;
    logic                            b_valid;
    logic [1:0]                      b_resp;
    logic [CFG_SYSBUS_ID_BITS-1:0]   b_id;
    logic [CFG_SYSBUS_USER_BITS-1:0] b_user;
    logic                            ar_ready;
    logic                            r_valid;
    logic [1:0]                      r_resp;
    logic [CFG_SYSBUS_DATA_BITS-1:0] r_data;
    logic                            r_last;
    logic [CFG_SYSBUS_ID_BITS-1:0]   r_id;
    logic [CFG_SYSBUS_USER_BITS-1:0] r_user;
  } axi4_master_in_type;
endpackage

module axi_mst
  import types_amba_pkg::*;
#(
  parameter int          id             = 0,
  parameter int unsigned timeout_cycles = 1024
) (
  input  logic                             i_clk,
  input  logic                             i_nrst,
  input  axi4_master_in_type               i_xmsti,
  output axi4_master_out_type              o_xmsto,
  input  logic                             i_req_valid,
  output logic                             o_req_ready,
  input  logic [CFG_SYSBUS_ADDR_BITS-1:0]  i_req_addr,
  input  logic                             i_req_write,
  input  logic [2:0]                       i_req_size,
  input  logic [CFG_SYSBUS_DATA_BITS-1:0]  i_req_wdata,
  input  logic [CFG_SYSBUS_DATA_BYTES-1:0] i_req_wstrb,
  output logic                             o_resp_valid,
  output logic [CFG_SYSBUS_DATA_BITS-1:0]  o_resp_rdata,
  output logic                             o_resp_err,
  input  logic                             i_resp_ready
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_AR   = 3'd1;
  localparam logic [2:0] ST_R    = 3'd2;
  localparam logic [2:0] ST_AWW  = 3'd3;
  localparam logic [2:0] ST_B    = 3'd4;
  localparam logic [2:0] ST_RESP = 3'd5;

  logic [2:0]                       r_state;
  logic [2:0]                       w_state_next;
  logic                             r_ar_valid;
  logic                             r_aw_valid;
  logic                             r_w_valid;
  logic                             r_r_ready;
  logic                             r_b_ready;
  logic [CFG_SYSBUS_ADDR_BITS-1:0]  r_addr;
  logic [2:0]                       r_size;
  logic [CFG_SYSBUS_DATA_BITS-1:0]  r_wdata;
  logic [CFG_SYSBUS_DATA_BYTES-1:0] r_wstrb;
  logic                             r_req_ready;
  logic                             r_resp_valid;
  logic [CFG_SYSBUS_DATA_BITS-1:0]  r_resp_rdata;
  logic                             r_resp_err;

  logic w_accept;
  logic w_aw_done;
  logic w_w_done;
  logic w_wait;
  logic w_timeout;

  assign w_accept  = (r_state == ST_IDLE) && i_req_valid && r_req_ready;
  assign w_aw_done = !r_aw_valid || i_xmsti.aw_ready;
  assign w_w_done  = !r_w_valid || i_xmsti.w_ready;
  assign w_wait    = (r_state == ST_AR) || (r_state == ST_R) ||
                     (r_state == ST_AWW) || (r_state == ST_B);

`ifdef AXI_MST_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(timeout_cycles - 1);
  logic [15:0] r_wdog;

  // The timeout fires on the edge that ends the timeout_cycles-th waiting clock.
  assign w_timeout = w_wait && (r_wdog == TIMEOUT_LAST);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_wdog <= '0;
    end else if (!w_wait || (w_state_next != r_state)) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + 16'd1;
    end
  end
`else
  logic w_unused_cfg;
  assign w_timeout    = 1'b0;
  assign w_unused_cfg = (timeout_cycles == 32'd0);
`endif

  always_comb begin
    // NOTE: default first so every path assigns w_state_next and no latch is inferred.
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = i_req_write ? ST_AWW : ST_AR;
      ST_AR:   if (i_xmsti.ar_ready) w_state_next = ST_R;
      ST_R:    if (i_xmsti.r_valid) w_state_next = ST_RESP;
      ST_AWW:  if (w_aw_done && w_w_done) w_state_next = ST_B;
      ST_B:    if (i_xmsti.b_valid) w_state_next = ST_RESP;
      ST_RESP: if (i_resp_ready) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
    if (w_timeout) w_state_next = ST_RESP;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      // NOTE: the request/response datapath is reset too; it is a handful of flops, not a memory.
      r_state      <= ST_IDLE;
      r_ar_valid   <= 1'b0;
      r_aw_valid   <= 1'b0;
      r_w_valid    <= 1'b0;
      r_r_ready    <= 1'b0;
      r_b_ready    <= 1'b0;
      r_addr       <= '0;
      r_size       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every branch sees pre-edge state.
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_addr      <= i_req_addr;
            r_size      <= i_req_size;
            r_wdata     <= i_req_wdata;
            r_wstrb     <= i_req_wstrb;
            if (i_req_write) begin
              r_aw_valid <= 1'b1;
              r_w_valid  <= 1'b1;
            end else begin
              r_ar_valid <= 1'b1;
            end
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        ST_AR: begin
          if (i_xmsti.ar_ready) begin
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b1;
          end
        end
        ST_R: begin
          if (i_xmsti.r_valid) begin
            r_r_ready    <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= i_xmsti.r_data;
            r_resp_err   <= i_xmsti.r_resp[1];
          end
        end
        ST_AWW: begin
          if (i_xmsti.aw_ready) r_aw_valid <= 1'b0;
          if (i_xmsti.w_ready)  r_w_valid  <= 1'b0;
          if (w_aw_done && w_w_done) r_b_ready <= 1'b1;
        end
        ST_B: begin
          if (i_xmsti.b_valid) begin
            r_b_ready    <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= '0;
            r_resp_err   <= i_xmsti.b_resp[1];
          end
        end
        ST_RESP: begin
          if (i_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: begin
          r_ar_valid   <= 1'b0;
          r_aw_valid   <= 1'b0;
          r_w_valid    <= 1'b0;
          r_r_ready    <= 1'b0;
          r_b_ready    <= 1'b0;
          r_req_ready  <= 1'b0;
          r_resp_valid <= 1'b0;
        end
      endcase
      // Watchdog abort overrides whatever handshake the waiting state saw.
      if (w_timeout) begin
        r_ar_valid   <= 1'b0;
        r_aw_valid   <= 1'b0;
        r_w_valid    <= 1'b0;
        r_r_ready    <= 1'b0;
        r_b_ready    <= 1'b0;
        r_resp_valid <= 1'b1;
        r_resp_rdata <= '0;
        r_resp_err   <= 1'b1;
      end
    end
  end

  always_comb begin
    o_xmsto                = '0;
    o_xmsto.ar_valid       = r_ar_valid;
    o_xmsto.ar_bits.addr   = r_addr;
    o_xmsto.ar_bits.size   = r_size;
    o_xmsto.ar_bits.burst  = AXI_BURST_INCR;
    o_xmsto.ar_id          = CFG_SYSBUS_ID_BITS'(id);
    o_xmsto.r_ready        = r_r_ready;
    o_xmsto.aw_valid       = r_aw_valid;
    o_xmsto.aw_bits.addr   = r_addr;
    o_xmsto.aw_bits.size   = r_size;
    o_xmsto.aw_bits.burst  = AXI_BURST_INCR;
    o_xmsto.aw_id          = CFG_SYSBUS_ID_BITS'(id);
    o_xmsto.w_valid        = r_w_valid;
    o_xmsto.w_data         = r_wdata;
    o_xmsto.w_strb         = r_wstrb;
    o_xmsto.w_last         = 1'b1;
    o_xmsto.b_ready        = r_b_ready;
  end

  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;

  // Response fields the master does not need (ids, user, last, low resp bit).
  logic w_unused;
  assign w_unused = ^{i_xmsti.b_resp[0], i_xmsti.b_id, i_xmsti.b_user,
                      i_xmsti.r_resp[0], i_xmsti.r_last, i_xmsti.r_id, i_xmsti.r_user};

endmodule

// File: tb/tb_axi_mst.sv
// Directed bench for axi_mst: reads, writes, error responses, backpressure, reset abort
// and the optional AXI_MST_TIMEOUT_EN watchdog.
module tb_axi_mst;
  import types_amba_pkg::*;

  logic                             clk;
  logic                             rst_n;
  axi4_master_in_type               xi;
  axi4_master_out_type              xo;
  logic                             req_valid;
  logic                             req_ready;
  logic [CFG_SYSBUS_ADDR_BITS-1:0]  req_addr;
  logic                             req_write;
  logic [2:0]                       req_size;
  logic [CFG_SYSBUS_DATA_BITS-1:0]  req_wdata;
  logic [CFG_SYSBUS_DATA_BYTES-1:0] req_wstrb;
  logic                             resp_valid;
  logic [CFG_SYSBUS_DATA_BITS-1:0]  resp_rdata;
  logic                             resp_err;
  logic                             resp_ready;

  int n_checks = 0;
  int n_errors = 0;

  axi_mst #(.id(3), .timeout_cycles(16)) dut (
    .i_clk        (clk),
    .i_nrst       (rst_n),
    .i_xmsti      (xi),
    .o_xmsto      (xo),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_addr   (req_addr),
    .i_req_write  (req_write),
    .i_req_size   (req_size),
    .i_req_wdata  (req_wdata),
    .i_req_wstrb  (req_wstrb),
    .o_resp_valid (resp_valid),
    .o_resp_rdata (resp_rdata),
    .o_resp_err   (resp_err),
    .i_resp_ready (resp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one clock; returns just after the accepting edge.
  task automatic issue(input logic wr, input logic [47:0] a, input logic [2:0] sz,
                       input logic [63:0] wd, input logic [7:0] ws);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_size  = sz;
    req_wdata = wd;
    req_wstrb = ws;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    int lat;
    int n;
    xi         = '0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_write  = 1'b0;
    req_size   = '0;
    req_wdata  = '0;
    req_wstrb  = '0;
    resp_ready = 1'b0;

    // Reset state
    step(); step();
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_ar_valid", 64'(xo.ar_valid), 64'd0);
    check("rst_aw_valid", 64'(xo.aw_valid), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    rst_n = 1'b1;
    #1;
    check("rel_ready_still_low", 64'(req_ready), 64'd0);
    step();
    check("rel_ready_first_clk", 64'(req_ready), 64'd1);

    // Read 0x1000 size 3 from a zero-wait slave; accept edge counts as clock 1
    xi.ar_ready = 1'b1;
    issue(1'b0, 48'h1000, 3'd3, 64'd0, 8'd0);
    check("rd_req_ready_drop", 64'(req_ready), 64'd0);
    check("rd_ar_valid", 64'(xo.ar_valid), 64'd1);
    check("rd_ar_addr", 64'(xo.ar_bits.addr), 64'h1000);
    check("rd_ar_size", 64'(xo.ar_bits.size), 64'd3);
    check("rd_ar_len", 64'(xo.ar_bits.len), 64'd0);
    check("rd_ar_burst", 64'(xo.ar_bits.burst), 64'd1);
    check("rd_ar_id", 64'(xo.ar_id), 64'd3);
    xi.r_data = 64'h1122334455667788;
    xi.r_resp = AXI_RESP_OKAY;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      if (xo.r_ready) xi.r_valid = 1'b1;
      step();
      lat++;
    end
    xi.r_valid  = 1'b0;
    xi.ar_ready = 1'b0;
    check("rd_latency", 64'(lat), 64'd3);
    check("rd_resp_valid", 64'(resp_valid), 64'd1);
    check("rd_rdata", resp_rdata, 64'h1122334455667788);
    check("rd_err", 64'(resp_err), 64'd0);
    check("rd_r_ready_clr", 64'(xo.r_ready), 64'd0);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("rd_resp_consumed", 64'(resp_valid), 64'd0);
    check("rd_req_ready_back", 64'(req_ready), 64'd1);

    // Write 0x2008, w_ready two clocks ahead of aw_ready
    issue(1'b1, 48'h2008, 3'd0, 64'hAA, 8'h01);
    check("wr_aw_valid", 64'(xo.aw_valid), 64'd1);
    check("wr_w_valid", 64'(xo.w_valid), 64'd1);
    check("wr_w_last", 64'(xo.w_last), 64'd1);
    check("wr_aw_addr", 64'(xo.aw_bits.addr), 64'h2008);
    check("wr_w_data", xo.w_data, 64'hAA);
    check("wr_w_strb", 64'(xo.w_strb), 64'h01);
    xi.w_ready = 1'b1;
    step();
    xi.w_ready = 1'b0;
    check("wr_w_done", 64'(xo.w_valid), 64'd0);
    check("wr_aw_pending", 64'(xo.aw_valid), 64'd1);
    step();
    check("wr_w_once", 64'(xo.w_valid), 64'd0);
    check("wr_aw_still", 64'(xo.aw_valid), 64'd1);
    check("wr_b_ready_wait", 64'(xo.b_ready), 64'd0);
    xi.aw_ready = 1'b1;
    step();
    xi.aw_ready = 1'b0;
    check("wr_aw_done", 64'(xo.aw_valid), 64'd0);
    check("wr_b_ready", 64'(xo.b_ready), 64'd1);
    xi.b_valid = 1'b1;
    xi.b_resp  = AXI_RESP_OKAY;
    step();
    xi.b_valid = 1'b0;
    check("wr_resp_valid", 64'(resp_valid), 64'd1);
    check("wr_err", 64'(resp_err), 64'd0);
    check("wr_rdata_zero", resp_rdata, 64'd0);
    check("wr_b_ready_clr", 64'(xo.b_ready), 64'd0);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;

    // Write with aw and w accepted in the same cycle, DECERR response
    issue(1'b1, 48'h3000, 3'd2, 64'h55, 8'hF0);
    xi.aw_ready = 1'b1;
    xi.w_ready  = 1'b1;
    step();
    xi.aw_ready = 1'b0;
    xi.w_ready  = 1'b0;
    check("wr2_both_done", 64'({xo.aw_valid, xo.w_valid, xo.b_ready}), 64'b001);
    xi.b_valid = 1'b1;
    xi.b_resp  = AXI_RESP_DECERR;
    step();
    xi.b_valid = 1'b0;
    check("wr2_err", 64'(resp_err), 64'd1);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;

    // Read with SLVERR, response held five clocks while requests are offered
    xi.ar_ready = 1'b1;
    issue(1'b0, 48'h4000, 3'd2, 64'd0, 8'd0);
    step();
    xi.ar_ready = 1'b0;
    xi.r_valid  = 1'b1;
    xi.r_data   = 64'hDEADBEEF;
    xi.r_resp   = AXI_RESP_SLVERR;
    step();
    xi.r_valid  = 1'b0;
    req_valid   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold%0d_valid", i), 64'(resp_valid), 64'd1);
      check($sformatf("hold%0d_rdata", i), resp_rdata, 64'hDEADBEEF);
      check($sformatf("hold%0d_err", i), 64'(resp_err), 64'd1);
      check($sformatf("hold%0d_req_ready", i), 64'(req_ready), 64'd0);
      check($sformatf("hold%0d_no_ar", i), 64'(xo.ar_valid), 64'd0);
      step();
    end
    resp_ready = 1'b1;
    step();
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    check("hold_released", 64'(resp_valid), 64'd0);
    check("hold_req_ready", 64'(req_ready), 64'd1);
    step();

    // Reset pulse while in AwW
    issue(1'b1, 48'h5000, 3'd3, 64'h1, 8'hFF);
    check("rstw_aw_valid", 64'(xo.aw_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rstw_aw_cleared", 64'(xo.aw_valid), 64'd0);
    check("rstw_w_cleared", 64'(xo.w_valid), 64'd0);
    check("rstw_req_ready", 64'(req_ready), 64'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    check("rstw_ready_after", 64'(req_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rstw_no_resp%0d", i), 64'(resp_valid), 64'd0);
      check($sformatf("rstw_no_aw%0d", i), 64'(xo.aw_valid), 64'd0);
      step();
    end

    // Read to a slave that never raises ar_ready
    issue(1'b0, 48'h6000, 3'd3, 64'd0, 8'd0);
`ifdef AXI_MST_TIMEOUT_EN
    n = 0;
    while (xo.ar_valid && n < 200) begin
      n++;
      step();
    end
    check("to_ar_cycles", 64'(n), 64'd16);
    check("to_resp_valid", 64'(resp_valid), 64'd1);
    check("to_err", 64'(resp_err), 64'd1);
    check("to_rdata", resp_rdata, 64'd0);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("to_req_ready", 64'(req_ready), 64'd1);
`else
    n = 0;
    for (int i = 0; i < 120; i++) begin
      if (xo.ar_valid) n++;
      step();
    end
    check("noto_ar_held", 64'(n), 64'd120);
    check("noto_ar_valid", 64'(xo.ar_valid), 64'd1);
    check("noto_no_resp", 64'(resp_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    check("noto_rst_clear", 64'(xo.ar_valid), 64'd0);
    step();
    rst_n = 1'b1;
    step();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
